// File: rtl/apb_reg_slave_pkg.sv
// Shared types and helpers for the APB register slave.
// Imported by the decoder and the top-level completer.
package apb_reg_slave_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int BYTE_OFFS_BITS = 2;

    function automatic int max_idx(input int n_rw, input int n_ro);
        return n_rw + n_ro - 1;
    endfunction

endpackage

// File: rtl/apb_reg_slave_if.sv
// APB bus bundle between the environment driver and the register slave.
// Carries setup/access phase signals and the completer response.
interface apb_reg_slave_if #(
    parameter int AW = 32,
    parameter int DW = 32
);

    logic [AW-1:0] paddr;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_reg_decoder.sv
// Combinational address decode for the register slave.
// Classifies a request as RW, RO or illegal and yields the bank-local index.
module apb_reg_decoder
    import apb_reg_slave_pkg::*;
#(
    parameter int APB_AW = 32,
    parameter int N_RW   = 4,
    parameter int N_RO   = 4,
    parameter int IDXW   = 3
) (
    input  logic [APB_AW-1:0] addr,
    input  logic              write,
    output logic              is_rw,
    output logic              is_ro,
    output logic [IDXW-1:0]   idx,
    output logic              err
);

    localparam int WW = APB_AW - BYTE_OFFS_BITS;
    localparam logic [WW-1:0] RW_END = WW'(N_RW);
    localparam logic [WW-1:0] LAST   = WW'(max_idx(N_RW, N_RO));

    logic [WW-1:0] word;
    logic          aligned;

    assign word    = addr[APB_AW-1:BYTE_OFFS_BITS];
    assign aligned = (addr[BYTE_OFFS_BITS-1:0] == '0);

    assign is_rw = aligned && (word < RW_END);
    assign is_ro = aligned && (word >= RW_END) && (word <= LAST);

    // RO index is relative to the start of the RO bank
    assign idx = is_ro ? IDXW'(word - RW_END) : IDXW'(word);
    assign err = !(is_rw || is_ro) || (is_ro && write);

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer with RW config bank, RO status bank and fixed wait states.
// Responses are fully registered so bus outputs stay stable through RESP.
module apb_reg_slave
    import apb_reg_slave_pkg::*;
#(
    parameter int                APB_AW      = 32,
    parameter int                APB_DW      = 32,
    parameter int                N_RW        = 4,
    parameter int                N_RO        = 4,
    parameter int                WAIT_CYCLES = 0,
    parameter logic [APB_DW-1:0] RW_RST      = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    apb_reg_slave_if.slave         apb,
    input  logic [N_RO*APB_DW-1:0] ro_data,
    output logic [N_RW*APB_DW-1:0] reg_q,
    output logic [N_RW-1:0]        wr_stb
);

    localparam int NREG = N_RW + N_RO;
    localparam int IDXW = (NREG > 1) ? $clog2(NREG) : 1;

    typedef logic [APB_DW-1:0] word_t;

    state_t                      state_q, state_d;
    logic [3:0]                  cnt_q, cnt_d;
    logic [APB_AW-1:0]           addr_q, addr_d;
    logic                        wr_q, wr_d;
    word_t                       wdata_q, wdata_d;
    logic [IDXW-1:0]             idx_q, idx_d;
    word_t                       prdata_q, prdata_d;
    logic                        pslverr_q, pslverr_d;
    logic                        pready_q, pready_d;
    logic [N_RW-1:0][APB_DW-1:0] regs_q, regs_d;
    logic [N_RW-1:0]             wr_stb_q, wr_stb_d;

    logic [N_RO-1:0][APB_DW-1:0] ro_w;
    logic [APB_AW-1:0]           req_addr;
    logic                        req_wr;
    logic                        dec_rw, dec_ro, dec_err;
    logic [IDXW-1:0]             dec_idx;
    word_t                       rd_word;
    logic                        enter_resp;

    assign ro_w = ro_data;

    // With no wait states the response is formed on the setup edge itself
    assign req_addr = (state_q == IDLE) ? apb.paddr : addr_q;
    assign req_wr   = (state_q == IDLE) ? apb.pwrite : wr_q;

    apb_reg_decoder #(
        .APB_AW(APB_AW),
        .N_RW  (N_RW),
        .N_RO  (N_RO),
        .IDXW  (IDXW)
    ) u_dec (
        .addr (req_addr),
        .write(req_wr),
        .is_rw(dec_rw),
        .is_ro(dec_ro),
        .idx  (dec_idx),
        .err  (dec_err)
    );

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < N_RW; i++) begin
            if (dec_rw && dec_idx == IDXW'(i)) rd_word = regs_q[i];
        end
        for (int i = 0; i < N_RO; i++) begin
            if (dec_ro && dec_idx == IDXW'(i)) rd_word = ro_w[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        idx_d      = idx_q;
        prdata_d   = prdata_q;
        pslverr_d  = pslverr_q;
        pready_d   = pready_q;
        regs_d     = regs_q;
        wr_stb_d   = '0;
        enter_resp = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (apb.psel && !apb.penable) begin
                    addr_d  = apb.paddr;
                    wr_d    = apb.pwrite;
                    wdata_d = apb.pwdata;
                    if (WAIT_CYCLES == 0) begin
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (!apb.psel) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (!apb.psel || apb.penable) begin
                    if (apb.psel && wr_q && !pslverr_q) begin
                        for (int i = 0; i < N_RW; i++) begin
                            if (idx_q == IDXW'(i)) begin
                                regs_d[i]   = wdata_q;
                                wr_stb_d[i] = 1'b1;
                            end
                        end
                    end
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    prdata_d  = '0;
                    pslverr_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_resp) begin
            state_d   = RESP;
            pready_d  = 1'b1;
            idx_d     = dec_idx;
            pslverr_d = dec_err;
            prdata_d  = (dec_err || req_wr) ? '0 : rd_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            idx_q     <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            pready_q  <= 1'b0;
            regs_q    <= {N_RW{RW_RST}};
            wr_stb_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            idx_q     <= idx_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            pready_q  <= pready_d;
            regs_q    <= regs_d;
            wr_stb_q  <= wr_stb_d;
        end
    end

    assign apb.prdata  = prdata_q;
    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
    assign reg_q       = regs_q;
    assign wr_stb      = wr_stb_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave at 0, 2 and 3 wait states.
// All three instances share one bus driver; dsel picks the one being checked.
module tb_apb_reg_slave;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic [31:0]  paddr   = '0;
    logic         psel    = 1'b0;
    logic         penable = 1'b0;
    logic         pwrite  = 1'b0;
    logic [31:0]  pwdata  = '0;
    logic [127:0] ro_data = '0;

    int total = 0;
    int bad   = 0;
    int dsel  = 0;

    logic         rdy_a [3];
    logic         err_a [3];
    logic [31:0]  rd_a  [3];
    logic [127:0] rq_a  [3];
    logic [3:0]   stb_a [3];

    logic         pready_s, err_s;
    logic [31:0]  rd_s;
    logic [127:0] rq_s;
    logic [3:0]   stb_s;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_reg_slave_if #(.AW(32), .DW(32)) bus ();

        assign bus.paddr   = paddr;
        assign bus.psel    = psel;
        assign bus.penable = penable;
        assign bus.pwrite  = pwrite;
        assign bus.pwdata  = pwdata;

        apb_reg_slave #(
            .APB_AW     (32),
            .APB_DW     (32),
            .N_RW       (4),
            .N_RO       (4),
            .WAIT_CYCLES((g == 0) ? 0 : (g == 1) ? 2 : 3),
            .RW_RST     (32'h0)
        ) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .apb    (bus),
            .ro_data(ro_data),
            .reg_q  (rq_a[g]),
            .wr_stb (stb_a[g])
        );

        assign rdy_a[g] = bus.pready;
        assign err_a[g] = bus.pslverr;
        assign rd_a[g]  = bus.prdata;
    end

    assign pready_s = rdy_a[dsel];
    assign err_s    = err_a[dsel];
    assign rd_s     = rd_a[dsel];
    assign rq_s     = rq_a[dsel];
    assign stb_s    = stb_a[dsel];

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Entered just after a posedge; leaves just after the completion edge
    task automatic xfer(input logic [31:0] a, input logic w,
                        input logic [31:0] d, output logic [31:0] rd,
                        output logic er, output int nw);
        paddr   = a;
        pwrite  = w;
        pwdata  = d;
        psel    = 1'b1;
        penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        nw = 0;
        @(negedge clk);
        while (!pready_s && nw < 64) begin
            nw++;
            @(negedge clk);
        end
        rd = rd_s;
        er = err_s;
        @(posedge clk); #1;
    endtask

    task automatic settle(input string tag, input logic [3:0] stb_exp,
                          input logic [127:0] rq_exp);
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge clk);
        check({tag, "_stb"}, 128'(stb_s), 128'(stb_exp));
        @(negedge clk);
        check({tag, "_stb_off"}, 128'(stb_s), 128'h0);
        check({tag, "_regs"}, rq_s, rq_exp);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          nw;
        logic [127:0] rq_exp;

        // reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_pready", 128'(pready_s), 128'h0);
        check("rst_prdata", 128'(rd_s), 128'h0);
        check("rst_pslverr", 128'(err_s), 128'h0);
        check("rst_wr_stb", 128'(stb_s), 128'h0);
        check("rst_regs", rq_s, 128'h0);
        check("rst_x", {127'd0, $isunknown({pready_s, rd_s, err_s,
                                             stb_s, rq_s})}, 128'h0);
        @(posedge clk); #1;

        // zero wait states: write word1
        rq_exp = {64'h0, 32'hA5A5_0001, 32'h0};
        xfer(32'h04, 1'b1, 32'hA5A5_0001, rd, er, nw);
        check("t2_wait", 128'(nw), 128'd0);
        check("t2_err", 128'(er), 128'h0);
        check("t2_prdata", 128'(rd), 128'h0);
        settle("t2", 4'b0010, rq_exp);

        xfer(32'h04, 1'b0, 32'h0, rd, er, nw);
        check("rb_prdata", 128'(rd), 128'hA5A5_0001);
        check("rb_err", 128'(er), 128'h0);
        settle("rb", 4'b0000, rq_exp);

        // illegal accesses
        xfer(32'h10, 1'b1, 32'h1234, rd, er, nw);
        check("e_ro_err", 128'(er), 128'h1);
        check("e_ro_prdata", 128'(rd), 128'h0);
        settle("e_ro", 4'b0000, rq_exp);

        xfer(32'h06, 1'b0, 32'h0, rd, er, nw);
        check("e_mis_err", 128'(er), 128'h1);
        check("e_mis_prdata", 128'(rd), 128'h0);
        settle("e_mis", 4'b0000, rq_exp);

        xfer(32'h40, 1'b0, 32'h0, rd, er, nw);
        check("e_oor_err", 128'(er), 128'h1);
        check("e_oor_prdata", 128'(rd), 128'h0);
        settle("e_oor", 4'b0000, rq_exp);

        // two wait states, RO read held through RESP
        do_reset();
        dsel    = 1;
        ro_data = {96'h0, 32'hDEAD_BEEF};
        paddr   = 32'h10;
        pwrite  = 1'b0;
        psel    = 1'b1;
        penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        nw = 0;
        @(negedge clk);
        while (!pready_s && nw < 64) begin
            nw++;
            @(negedge clk);
        end
        check("t3_wait", 128'(nw), 128'd2);
        check("t3_err", 128'(err_s), 128'h0);
        check("t3_prdata", 128'(rd_s), 128'hDEAD_BEEF);
        ro_data[31:0] = 32'h1111_2222;
        #2;
        check("t3_hold", 128'(rd_s), 128'hDEAD_BEEF);
        @(posedge clk); #1;
        settle("t3", 4'b0000, 128'h0);
        check("t3_idle_prdata", 128'(rd_s), 128'h0);

        // abort during wait states
        do_reset();
        dsel    = 2;
        paddr   = 32'h00;
        pwrite  = 1'b1;
        pwdata  = 32'hCAFE_0000;
        psel    = 1'b1;
        penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check("ab_rdy_acc", 128'(pready_s), 128'h0);
        @(posedge clk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ab_rdy_idle", 128'(pready_s), 128'h0);
        end
        check("ab_regs", rq_s, 128'h0);
        @(posedge clk); #1;
        xfer(32'h00, 1'b1, 32'h0000_5A5A, rd, er, nw);
        check("ab_next_wait", 128'(nw), 128'd3);
        check("ab_next_err", 128'(er), 128'h0);
        settle("ab_next", 4'b0001, {96'h0, 32'h0000_5A5A});

        // reset while in RESP, then back-to-back pair
        do_reset();
        dsel = 1;
        xfer(32'h08, 1'b1, 32'h0000_0077, rd, er, nw);
        settle("t6_pre", 4'b0100, {32'h0, 32'h77, 64'h0});
        paddr   = 32'h08;
        pwrite  = 1'b0;
        psel    = 1'b1;
        penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        nw = 0;
        @(negedge clk);
        while (!pready_s && nw < 64) begin
            nw++;
            @(negedge clk);
        end
        check("t6_resp_prdata", 128'(rd_s), 128'h77);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_pready", 128'(pready_s), 128'h0);
        check("t6_rst_prdata", 128'(rd_s), 128'h0);
        check("t6_rst_pslverr", 128'(err_s), 128'h0);
        check("t6_rst_regs", rq_s, 128'h0);
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(32'h08, 1'b1, 32'h1357_9BDF, rd, er, nw);
        check("t6_wr_err", 128'(er), 128'h0);
        xfer(32'h08, 1'b0, 32'h0, rd, er, nw);
        check("t6_rd_wait", 128'(nw), 128'd2);
        check("t6_rd_err", 128'(er), 128'h0);
        check("t6_rd_data", 128'(rd), 128'h1357_9BDF);
        settle("t6_post", 4'b0000, {32'h0, 32'h1357_9BDF, 64'h0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
